arith_accum_8b: RTL and testbench

Sequential accumulator stage that sits downstream of the team's 8-bit combinational adder and reuses it as its datapath. It accepts a job (an operand count), consumes that many 8-bit operands over a latency-insensitive val/rdy stream, and sums them modulo 256 while tracking carry-out. It then presents the sum and a sticky overflow flag on an output val/rdy interface. It is the building block for multi-operand reductions in the comb_arith/seq_arith problem family.

---
 rtl/arith_pkg.sv | 13 +
 rtl/arith_add_8b_c.sv | 14 +
 rtl/arith_accum_8b.sv | 99 +++++++++
 tb/tb_arith_accum_8b.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and widths for the sequential arithmetic blocks.
// Imported by the accumulator top and its adder datapath.
package arith_pkg;

    localparam int ARITH_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/arith_add_8b_c.sv
// Combinational 8-bit adder returning {carry, sum}.
// Shared datapath for the accumulator stage.
module arith_add_8b_c
    import arith_pkg::*;
(
    input  logic [ARITH_W-1:0] i_a,
    input  logic [ARITH_W-1:0] i_b,
    output logic [ARITH_W-1:0] o_sum,
    output logic               o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/arith_accum_8b.sv
// Multi-operand accumulator: takes a job count, sums that many operands
// mod 256 with a sticky carry flag, and presents the result on val/rdy.
module arith_accum_8b
    import arith_pkg::*;
#(
    parameter int CNT_W = 4
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_val,
    output logic               start_rdy,
    input  logic [CNT_W-1:0]   start_cnt,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [ARITH_W-1:0] in_data,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [ARITH_W-1:0] out_sum,
    output logic               out_ovf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_rem;
    logic [ARITH_W-1:0] r_sum;
    logic               r_ovf;

    logic [ARITH_W-1:0] w_add_sum;
    logic               w_add_c;
    logic               w_start_fire;
    logic               w_in_fire;
    logic               w_last;

    arith_add_8b_c u_add (
        .i_a     (r_sum),
        .i_b     (in_data),
        .o_sum   (w_add_sum),
        .o_carry (w_add_c)
    );

    // Ready/valid come only from registered state, never from inputs.
    assign start_rdy = (r_state == IDLE);
    assign in_rdy    = (r_state == ACCUM);
    assign out_val   = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_ovf   = r_ovf;

    assign w_start_fire = start_val && start_rdy;
    assign w_in_fire    = in_val && in_rdy;
    assign w_last       = (r_rem == CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start_val) begin
                    w_state_nxt = (start_cnt != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_val && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem <= '0;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_fire) begin
            r_rem <= start_cnt;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_in_fire) begin
            r_rem <= r_rem - CNT_W'(1);
            r_sum <= w_add_sum;
            r_ovf <= r_ovf | w_add_c;
        end
    end

endmodule

// File: tb/tb_arith_accum_8b.sv
// Self-checking bench for arith_accum_8b: a queue of expected results is
// filled as jobs are accepted and drained as results are handshaken.
module tb_arith_accum_8b;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start_val = 1'b0;
    logic             start_rdy;
    logic [CNT_W-1:0] start_cnt = '0;
    logic             in_val = 1'b0;
    logic             in_rdy;
    logic [7:0]       in_data = '0;
    logic             out_val;
    logic             out_rdy = 1'b0;
    logic [7:0]       out_sum;
    logic             out_ovf;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] sb_q[$];
    logic [7:0] ops[16];

    logic       held = 1'b0;
    logic [7:0] prev_sum;
    logic       prev_ovf;

    arith_accum_8b #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_val (start_val),
        .start_rdy (start_rdy),
        .start_cnt (start_cnt),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_start_rdy"}, 16'(start_rdy), 16'd1);
        check({tag, "_in_rdy"}, 16'(in_rdy), 16'd0);
        check({tag, "_out_val"}, 16'(out_val), 16'd0);
        check({tag, "_out_sum"}, 16'(out_sum), 16'h00);
        check({tag, "_out_ovf"}, 16'(out_ovf), 16'd0);
    endtask

    // Consumer side: pop and compare on each result handshake, and
    // require the result to stay stable while it is being stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else if (out_val) begin
            if (held) begin
                check("hold_sum", 16'(out_sum), 16'(prev_sum));
                check("hold_ovf", 16'(out_ovf), 16'(prev_ovf));
            end
            if (out_rdy) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 16'd1, 16'd0);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    check("res_sum", 16'(out_sum), 16'(e[7:0]));
                    check("res_ovf", 16'(out_ovf), 16'(e[8]));
                end
                held = 1'b0;
            end else begin
                held = 1'b1;
                prev_sum = out_sum;
                prev_ovf = out_ovf;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic start_job(input int cnt);
        int         t;
        logic [7:0] s;
        logic       o;
        logic [8:0] tmp;
        s = 8'h00;
        o = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            tmp = {1'b0, s} + {1'b0, ops[i]};
            s   = tmp[7:0];
            o   = o | tmp[8];
        end
        start_val = 1'b1;
        start_cnt = CNT_W'(cnt);
        t = 0;
        while (!start_rdy && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) begin
            check("start_tmo", 16'd0, 16'd1);
            start_val = 1'b0;
            return;
        end
        step();
        start_val = 1'b0;
        sb_q.push_back({o, s});
        if (cnt == 0) begin
            check("cnt0_out_val", 16'(out_val), 16'd1);
        end else begin
            check("job_in_rdy", 16'(in_rdy), 16'd1);
        end
    endtask

    task automatic send_ops(input int cnt, input int max_gap,
                            input bit last_chk);
        int t;
        for (int i = 0; i < cnt; i++) begin
            in_val = 1'b0;
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) step();
            end
            in_val  = 1'b1;
            in_data = ops[i];
            t = 0;
            while (!in_rdy && t < 100) begin
                step();
                t++;
            end
            if (t >= 100) begin
                check("op_tmo", 16'd0, 16'd1);
                in_val = 1'b0;
                return;
            end
            step();
        end
        in_val = 1'b0;
        if (last_chk) begin
            check("last_lat", 16'(out_val), 16'd1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) begin
            check("drain_tmo", 16'd0, 16'd1);
        end
    endtask

    initial begin
        repeat (3) step();
        check_reset_outs("rst");
        reset_n = 1'b1;
        step();
        check_reset_outs("idle");

        out_rdy = 1'b1;
        ops[0] = 8'h10; ops[1] = 8'h20; ops[2] = 8'h30;
        start_job(3);
        send_ops(3, 0, 1'b1);
        wait_drain();

        ops[0] = 8'hFF; ops[1] = 8'h02;
        start_job(2);
        send_ops(2, 0, 1'b1);
        wait_drain();

        ops[0] = 8'h05;
        start_job(1);
        send_ops(1, 0, 1'b1);
        wait_drain();

        in_val  = 1'b1;
        in_data = 8'hAA;
        start_job(0);
        check("cnt0_in_rdy", 16'(in_rdy), 16'd0);
        wait_drain();
        step();
        in_val = 1'b0;

        ops[0] = 8'h11; ops[1] = 8'h22;
        start_job(2);
        send_ops(2, 0, 1'b1);
        wait_drain();

        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) ops[i] = 8'($urandom_range(0, 255));
        ops[0] = 8'hF0;
        ops[1] = 8'h20;
        start_job(4);
        send_ops(4, 3, 1'b1);
        repeat (5) begin
            start_val = 1'b1;
            start_cnt = CNT_W'(1);
            step();
            check("stall_start_rdy", 16'(start_rdy), 16'd0);
            check("stall_out_val", 16'(out_val), 16'd1);
        end
        start_val = 1'b0;
        out_rdy   = 1'b1;
        wait_drain();
        step();
        check("after_hs_start_rdy", 16'(start_rdy), 16'd1);

        for (int j = 0; j < 6; j++) begin
            int c;
            c = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) ops[i] = 8'($urandom_range(0, 255));
            start_job(c);
            send_ops(c, 2, c != 0);
            wait_drain();
        end

        ops[0] = 8'h40; ops[1] = 8'h50; ops[2] = 8'h60; ops[3] = 8'h70;
        start_job(4);
        send_ops(2, 0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        sb_q.delete();
        step();
        step();
        reset_n = 1'b1;
        step();
        check_reset_outs("postrst");

        ops[0] = 8'h07;
        start_job(1);
        send_ops(1, 0, 1'b1);
        wait_drain();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
